// File: rtl/chunk_stream_pkg.sv
// Shared configuration, widths and types for the chunk stream packer.
package chunk_stream_pkg;

    localparam int WIDTH            = 16;
    localparam int CHUNK_SIZE       = 4;
    localparam int DEPTH            = 8;
    localparam int WORDS_PER_PACKET = 16;
    localparam int WORD_W           = WIDTH * CHUNK_SIZE;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int beat_w(input int wpp);
        return (wpp > 1) ? $clog2(wpp) : 1;
    endfunction

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int BEAT_W = beat_w(WORDS_PER_PACKET);

    typedef logic [WORD_W-1:0] chunk_word_t;

endpackage

// File: rtl/chunk_fifo.sv
// DEPTH-entry word FIFO: registered write, combinational read at rd_ptr.
module chunk_fifo
    import chunk_stream_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  chunk_word_t      wr_data,
    output chunk_word_t      rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    chunk_word_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/chunk_stream_packer.sv
// Buffers serializer words and emits them as an AXI-Stream packet stream.
// Define CHUNK_STREAM_OVF_CNT_EN to add the saturating ovf_count output.
module chunk_stream_packer
    import chunk_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_almost_full,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              overflow
`ifdef CHUNK_STREAM_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_count
`endif
);

    localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(DEPTH - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_PACKET - 1);

    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    chunk_word_t       rd_data;
    logic [BEAT_W-1:0] beat_cnt_reg;

    chunk_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_tvalid       = ~fifo_empty;
    assign pop            = m_tvalid & m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push           = in_valid & (~fifo_full | pop);
    assign drop           = in_valid & ~push;
    assign in_almost_full = (fifo_count >= AFULL_CNT);
    assign m_tlast        = m_tvalid & (beat_cnt_reg == LAST_BEAT);

    // Stale storage is masked so the data bus reads zero whenever no beat is offered.
    for (genvar gi = 0; gi < CHUNK_SIZE; gi++) begin : g_lane
        assign m_tdata[gi*WIDTH +: WIDTH] = m_tvalid ? rd_data[gi*WIDTH +: WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg <= '0;
        end else if (pop) begin
            beat_cnt_reg <= m_tlast ? '0 : beat_cnt_reg + 1'b1;
        end
    end

`ifdef CHUNK_STREAM_OVF_CNT_EN
    logic [15:0] ovf_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_reg <= '0;
        end else if (drop && (ovf_count_reg != 16'hFFFF)) begin
            ovf_count_reg <= ovf_count_reg + 16'd1;
        end
    end

    assign ovf_count = ovf_count_reg;
    assign overflow  = (ovf_count_reg != 16'd0);
`else
    logic overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_chunk_stream_packer.sv
// Randomized and directed bench for chunk_stream_packer against a queue-based model.
module tb_chunk_stream_packer;
    import chunk_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        m_tready = 1'b0;
    chunk_word_t in_data = '0;
    logic        in_almost_full;
    logic        m_tvalid;
    logic        m_tlast;
    logic        overflow;
    chunk_word_t m_tdata;
`ifdef CHUNK_STREAM_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    always #5 clk = ~clk;

    chunk_stream_packer dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_almost_full (in_almost_full),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tdata        (m_tdata),
        .m_tlast        (m_tlast),
        .overflow       (overflow)
`ifdef CHUNK_STREAM_OVF_CNT_EN
        ,
        .ovf_count      (ovf_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus packet beat position.
    chunk_word_t mq[$];
    int          m_beat   = 0;
    bit          m_ovf    = 1'b0;
    int          m_ovfcnt = 0;
    bit          chk_en   = 1'b0;

    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            m_beat   = 0;
            m_ovf    = 1'b0;
            m_ovfcnt = 0;
        end else begin
            do_pop  = (mq.size() > 0) && m_tready;
            do_push = in_valid && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) begin
                void'(mq.pop_front());
                m_beat = (m_beat == WORDS_PER_PACKET - 1) ? 0 : m_beat + 1;
            end
            if (do_push) mq.push_back(in_data);
            if (in_valid && !do_push) begin
                m_ovf = 1'b1;
                if (m_ovfcnt < 65535) m_ovfcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
            if (mq.size() != 0) check("tdata", m_tdata, mq[0]);
            check("tlast", 64'(m_tlast), 64'((mq.size() != 0) && (m_beat == WORDS_PER_PACKET - 1)));
            check("almost_full", 64'(in_almost_full), 64'(mq.size() >= DEPTH - 1));
            check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef CHUNK_STREAM_OVF_CNT_EN
            check("ovf_count", 64'(ovf_count), 64'(m_ovfcnt));
`endif
        end
    end

    // Called at a negedge: apply inputs, then advance to the next negedge.
    task automatic drive(input bit v, input chunk_word_t d, input bit r);
        in_valid = v;
        in_data  = d;
        m_tready = r;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        m_tready = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        chunk_word_t exp_q[$];

        @(negedge clk);
        do_reset(3);
        chk_en = 1'b1;

        // Reset state
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_afull", 64'(in_almost_full), 64'd0);
        check("rst_tdata", m_tdata, 64'd0);

        // Single word, one cycle latency
        drive(1'b1, 64'h0001_0002_0003_0004, 1'b1);
        check("single_tvalid", 64'(m_tvalid), 64'd1);
        check("single_tdata", m_tdata, 64'h0001_0002_0003_0004);
        drive(1'b0, '0, 1'b1);
        check("single_drained", 64'(m_tvalid), 64'd0);

        // Streaming 32 words: tlast on 15 and 31
        do_reset(1);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 64'(i), 1'b1);
            check("stream_tdata", m_tdata, 64'(i));
            check("stream_tlast", 64'(m_tlast), 64'((i == 15) || (i == 31)));
        end
        drive(1'b0, '0, 1'b1);

        // Fill with backpressure, two words dropped
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'(i), 1'b0);
            if (i == 5) check("fill_afull_6", 64'(in_almost_full), 64'd0);
            if (i == 6) check("fill_afull_7", 64'(in_almost_full), 64'd1);
        end
        check("fill_overflow", 64'(overflow), 64'd1);
        check("model_fill_size", 64'(mq.size()), 64'd8);
`ifdef CHUNK_STREAM_OVF_CNT_EN
        check("fill_ovf_count", 64'(ovf_count), 64'd2);
`endif
        for (int k = 0; k < 8; k++) begin
            check("fill_drain_tdata", m_tdata, 64'(k));
            drive(1'b0, '0, 1'b1);
        end
        check("fill_drain_empty", 64'(m_tvalid), 64'd0);
        check("fill_overflow_held", 64'(overflow), 64'd1);

        // Full FIFO with simultaneous push and pop: no drops, order kept
        do_reset(1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(100 + i), 1'b0);
            exp_q.push_back(64'(100 + i));
        end
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 64'(200 + j), 1'b1);
            void'(exp_q.pop_front());
            exp_q.push_back(64'(200 + j));
            check("full_pp_tdata", m_tdata, exp_q[0]);
            check("full_pp_afull", 64'(in_almost_full), 64'd1);
            check("full_pp_overflow", 64'(overflow), 64'd0);
        end
        check("model_full_size", 64'(mq.size()), 64'd8);
        repeat (8) drive(1'b0, '0, 1'b1);
        check("full_pp_drained", 64'(m_tvalid), 64'd0);

        // Reset mid-packet restarts beat numbering
        do_reset(1);
        for (int i = 0; i < 5; i++) drive(1'b1, 64'(i), 1'b1);
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 64'(50 + i), 1'b0);
        check("mid_stored", 64'(m_tvalid), 64'd1);
        do_reset(1);
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_afull", 64'(in_almost_full), 64'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 64'(300 + i), 1'b1);
            check("mid_tlast", 64'(m_tlast), 64'(i == 15));
        end
        drive(1'b0, '0, 1'b1);

        // Randomized traffic with phases of varying sink readiness
        do_reset(1);
        for (int c = 0; c < 3000; c++) begin
            int rdy_pct;
            rdy_pct = ((c / 200) % 3 == 0) ? 20 : (((c / 200) % 3 == 1) ? 90 : 55);
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                drive($urandom_range(0, 9) < 7, {$urandom, $urandom},
                      $urandom_range(0, 99) < rdy_pct);
            end
        end
        drive(1'b0, '0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
